// File: rtl/memory_controller.sv
// Word-addressed main memory with a two-port (CPU / IOP) req/ack arbiter.
// Each access walks IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack).
// The array has no reset, so its contents survive reset. Reads use a
// registered array output. The per-port read data is presented during DONE
// and then held in a register until the next read on that port.
module memory_controller #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [16:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        iop_req,
    input  logic        iop_write,
    input  logic [16:0] iop_address,
    input  logic [31:0] iop_wdata,
    output logic [31:0] iop_rdata,
    output logic        iop_ack,
    output logic        busy,
    output logic        addr_fault
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);
    localparam logic [3:0]  WS_INIT   = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_IOP = 1'b1;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        write_q, write_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] iop_rdata_q, iop_rdata_d;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] mem_rd_q;

    logic          pick;
    logic          in_range;
    logic          commit;
    logic          done_read;
    logic [AW-1:0] mem_idx;
    logic [31:0]   read_word;

    assign mem_idx   = addr_q[AW-1:0];
    assign in_range  = (addr_q < DEPTH_LIM);
    assign commit    = (state_q == S_ACCESS) && (wcnt_q == 4'd0);
    assign done_read = (state_q == S_DONE) && !write_q;
    // Out-of-range reads return zero; the array word is ignored.
    assign read_word = in_range ? mem_rd_q : 32'd0;

    // Array write on the commit edge (reset wins) plus an always-on registered read.
    always_ff @(posedge clock) begin
        if (!reset && commit && write_q && in_range) begin
            mem[mem_idx] <= wdata_q;
        end
        mem_rd_q <= mem[mem_idx];
    end

    // Arbitration, request capture and wait-state sequencing.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pick         = GRANT_CPU;
        if (cpu_req && iop_req) begin
            // A tie goes to whichever port was not served last.
            pick = (last_grant_q == GRANT_CPU) ? GRANT_IOP : GRANT_CPU;
        end else if (iop_req) begin
            pick = GRANT_IOP;
        end
        case (state_q)
            S_IDLE: begin
                if (cpu_req || iop_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    write_d      = (pick == GRANT_IOP) ? iop_write   : cpu_write;
                    addr_d       = (pick == GRANT_IOP) ? iop_address : cpu_address;
                    wdata_d      = (pick == GRANT_IOP) ? iop_wdata   : cpu_wdata;
                    wcnt_d       = WS_INIT;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data: the granted port sees the array word during DONE, then holds it.
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        iop_rdata_d = iop_rdata_q;
        if (done_read && (grant_q == GRANT_CPU)) begin
            cpu_rdata_d = read_word;
        end
        if (done_read && (grant_q == GRANT_IOP)) begin
            iop_rdata_d = read_word;
        end
    end

    // Control and data registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 4'd0;
            last_grant_q <= GRANT_IOP;
            grant_q      <= GRANT_CPU;
            write_q      <= 1'b0;
            addr_q       <= 17'd0;
            wdata_q      <= 32'd0;
            cpu_rdata_q  <= 32'd0;
            iop_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            iop_rdata_q  <= iop_rdata_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_d;
    assign iop_rdata  = iop_rdata_d;
    assign cpu_ack    = (state_q == S_DONE) && (grant_q == GRANT_CPU);
    assign iop_ack    = (state_q == S_DONE) && (grant_q == GRANT_IOP);
    assign busy       = (state_q != S_IDLE);
    assign addr_fault = (state_q == S_DONE) && !in_range;

endmodule
